// File: rtl/llr_window_sched_pkg.sv
// Shared defaults and state encoding for the sliding-window LLR sequencer.
package llr_window_sched_pkg;

  localparam int unsigned DefaultWin   = 64;
  localparam int unsigned DefaultWinW  = 6;
  localparam int unsigned DefaultKW    = 13;
  localparam int unsigned DefaultLeLat = 5;
  localparam int unsigned DefaultDLat  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StBwd,
    StDrain
  } state_e;

endpackage

// File: rtl/llr_window_sched_tag.sv
// llr_tag_delay: fixed-depth shift register carrying {valid, index} tags; the valid bit is
// the MSB and pending reports whether any stage still holds a valid tag.
module llr_tag_delay #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             pending
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) pending = pending | stage_q[i][WIDTH-1];
  end

endmodule

// File: rtl/llr_window_sched.sv
// llr_window_sched: per-frame forward/backward window sequencer with delayed Le/D index tags.
// Define LLR_SCHED_STALL_EN to add a stall input that freezes FWD/BWD sequencing.
module llr_window_sched
  import llr_window_sched_pkg::*;
#(
  parameter int unsigned WIN    = DefaultWin,
  parameter int unsigned WIN_W  = DefaultWinW,
  parameter int unsigned K_W    = DefaultKW,
  parameter int unsigned LE_LAT = DefaultLeLat,
  parameter int unsigned D_LAT  = DefaultDLat
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [K_W-1:0]   frame_len,
  output logic             busy,
  output logic             done,
  output logic             alpha_init,
  output logic             alpha_en,
  output logic [WIN_W-1:0] alpha_waddr,
  output logic             beta_init,
  output logic             beta_term,
  output logic             beta_en,
  output logic [WIN_W-1:0] alpha_raddr,
  output logic             llr_in_vld,
  output logic             le_vld,
  output logic [K_W-1:0]   le_idx,
  output logic             d_vld,
  output logic [K_W-1:0]   d_idx
`ifdef LLR_SCHED_STALL_EN
  ,
  input  logic             stall
`endif
);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0]   base_q, base_d;
  logic [K_W-1:0]   len_q, len_d;
  logic             llr_vld_q;
  logic [K_W-1:0]   llr_idx_q;

  logic             advance;
  logic [K_W-1:0]   rem;
  logic             last_win;
  logic [WIN_W-1:0] n_m1;
  logic [K_W-1:0]   base_nxt;
  logic             le_pending, d_pending, drained;
  logic [K_W:0]     le_tag, d_tag;

`ifdef LLR_SCHED_STALL_EN
  assign advance = ~stall;
`else
  assign advance = 1'b1;
`endif

  // Window size n = min(WIN, remaining); n_m1 wraps correctly when remaining == WIN.
  assign rem      = len_q - base_q;
  assign last_win = (rem <= K_W'(WIN));
  assign n_m1     = last_win ? (rem[WIN_W-1:0] - WIN_W'(1)) : WIN_W'(WIN - 1);
  assign base_nxt = base_q + K_W'(n_m1) + K_W'(1);
  assign drained  = ~llr_vld_q & ~le_pending & ~d_pending;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    len_d   = len_q;
    case (state_q)
      StIdle: begin
        if (start && (frame_len != '0)) begin
          len_d   = frame_len;
          base_d  = '0;
          cnt_d   = '0;
          state_d = StFwd;
        end
      end
      StFwd: begin
        // cnt stays at n-1 so the backward pass starts from the top of the window.
        if (advance) begin
          if (cnt_q == n_m1) state_d = StBwd;
          else               cnt_d   = cnt_q + WIN_W'(1);
        end
      end
      StBwd: begin
        if (advance) begin
          if (cnt_q == '0) begin
            base_d  = base_nxt;
            state_d = last_win ? StDrain : StFwd;
          end else begin
            cnt_d = cnt_q - WIN_W'(1);
          end
        end
      end
      StDrain: begin
        if (drained) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alpha_en    = 1'b0;
    alpha_init  = 1'b0;
    alpha_waddr = '0;
    beta_en     = 1'b0;
    beta_init   = 1'b0;
    beta_term   = 1'b0;
    alpha_raddr = '0;
    if (state_q == StFwd) begin
      alpha_en    = advance;
      alpha_init  = advance && (base_q == '0) && (cnt_q == '0);
      alpha_waddr = cnt_q;
    end
    if (state_q == StBwd) begin
      beta_en     = advance;
      beta_init   = advance && (cnt_q == n_m1);
      beta_term   = advance && (cnt_q == n_m1) && last_win;
      alpha_raddr = cnt_q;
    end
  end

  assign done = (state_q == StDrain) && drained;
  assign busy = (state_q != StIdle) && !done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      base_q    <= '0;
      len_q     <= '0;
      llr_vld_q <= 1'b0;
      llr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      len_q     <= len_d;
      llr_vld_q <= beta_en;
      llr_idx_q <= beta_en ? (base_q + K_W'(cnt_q)) : '0;
    end
  end

  assign llr_in_vld = llr_vld_q;

  llr_tag_delay #(
    .DEPTH (LE_LAT),
    .WIDTH (K_W + 1)
  ) u_le_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     ({llr_vld_q, llr_idx_q}),
    .dout    (le_tag),
    .pending (le_pending)
  );

  llr_tag_delay #(
    .DEPTH (D_LAT),
    .WIDTH (K_W + 1)
  ) u_d_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     ({llr_vld_q, llr_idx_q}),
    .dout    (d_tag),
    .pending (d_pending)
  );

  assign le_vld = le_tag[K_W];
  assign le_idx = le_tag[K_W-1:0];
  assign d_vld  = d_tag[K_W];
  assign d_idx  = d_tag[K_W-1:0];

endmodule

// File: tb/tb_llr_window_sched.sv
// Scoreboard bench for llr_window_sched: a window-level model queues expected strobes and
// tags per frame; a negedge monitor pops and compares whatever the DUT presents.
module tb_llr_window_sched;

  localparam int unsigned WIN     = 8;
  localparam int unsigned WIN_W   = 3;
  localparam int unsigned K_W     = 13;
  localparam int unsigned LE_LAT  = 5;
  localparam int unsigned D_LAT   = 4;
  localparam int unsigned MAX_LAT = (LE_LAT > D_LAT) ? LE_LAT : D_LAT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [K_W-1:0]   frame_len;
  logic             stall;
  logic             busy, done, alpha_init, alpha_en, beta_init, beta_term, beta_en;
  logic [WIN_W-1:0] alpha_waddr, alpha_raddr;
  logic             llr_in_vld, le_vld, d_vld;
  logic [K_W-1:0]   le_idx, d_idx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int aq[$], bq[$], le_q[$], d_q[$], lt_q[$], dt_q[$];
  int m_e;

  always #5 clk = ~clk;

  llr_window_sched #(
    .WIN    (WIN),
    .WIN_W  (WIN_W),
    .K_W    (K_W),
    .LE_LAT (LE_LAT),
    .D_LAT  (D_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .frame_len   (frame_len),
    .busy        (busy),
    .done        (done),
    .alpha_init  (alpha_init),
    .alpha_en    (alpha_en),
    .alpha_waddr (alpha_waddr),
    .beta_init   (beta_init),
    .beta_term   (beta_term),
    .beta_en     (beta_en),
    .alpha_raddr (alpha_raddr),
    .llr_in_vld  (llr_in_vld),
    .le_vld      (le_vld),
    .le_idx      (le_idx),
    .d_vld       (d_vld),
    .d_idx       (d_idx)
`ifdef LLR_SCHED_STALL_EN
    ,
    .stall       (stall)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: split frame into windows, forward ascending then backward descending.
  task automatic expect_frame(input int k);
    int base = 0;
    int n;
    while (base < k) begin
      n = (k - base < int'(WIN)) ? k - base : int'(WIN);
      for (int i = 0; i < n; i++) aq.push_back(((base == 0 && i == 0) ? 256 : 0) + i);
      for (int j = n - 1; j >= 0; j--) begin
        bq.push_back(((j == n - 1) ? 512 : 0) + ((j == n - 1 && base + n == k) ? 256 : 0) + j);
        le_q.push_back(base + j);
        d_q.push_back(base + j);
      end
      base += n;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cnt++;
    if (alpha_en) begin
      check("alpha_expected", int'(aq.size() > 0), 1);
      if (aq.size() > 0) begin
        m_e = aq.pop_front();
        check("alpha_init_waddr", int'(alpha_init) * 256 + int'(alpha_waddr), m_e);
      end
    end
    if (beta_en) begin
      check("beta_expected", int'(bq.size() > 0), 1);
      if (bq.size() > 0) begin
        m_e = bq.pop_front();
        check("beta_init_term_raddr",
              int'(beta_init) * 512 + int'(beta_term) * 256 + int'(alpha_raddr), m_e);
      end
      lt_q.push_back(cyc);
      dt_q.push_back(cyc);
    end
    if (le_vld) begin
      check("le_expected", int'(le_q.size() > 0 && lt_q.size() > 0), 1);
      if (le_q.size() > 0) check("le_idx", int'(le_idx), le_q.pop_front());
      if (lt_q.size() > 0) check("le_latency", cyc - lt_q.pop_front(), LE_LAT + 1);
    end
    if (d_vld) begin
      check("d_expected", int'(d_q.size() > 0 && dt_q.size() > 0), 1);
      if (d_q.size() > 0) check("d_idx", int'(d_idx), d_q.pop_front());
      if (dt_q.size() > 0) check("d_latency", cyc - dt_q.pop_front(), D_LAT + 1);
    end
    if (done) begin
      done_cnt++;
      check("busy_low_at_done", busy, 0);
      check("all_strobes_issued_at_done", aq.size() + bq.size(), 0);
      check("tags_drained_at_done", le_q.size() + d_q.size(), 0);
    end
  end

  function automatic longint all_outs();
    return {busy, done, alpha_init, alpha_en, alpha_waddr, beta_init, beta_term, beta_en,
            alpha_raddr, llr_in_vld, le_vld, le_idx, d_vld, d_idx};
  endfunction

  task automatic flush();
    aq.delete(); bq.delete(); le_q.delete(); d_q.delete(); lt_q.delete(); dt_q.delete();
  endtask

  task automatic run_frame(input int k, input bit poke, input bit do_stall);
    int d0, b0, t, extra;
    logic [WIN_W-1:0] hold;
    extra = 0;
    expect_frame(k);
    d0 = done_cnt;
    b0 = busy_cnt;
    @(posedge clk); #1 start = 1'b1; frame_len = K_W'(k);
    @(posedge clk); #1 start = 1'b0; frame_len = K_W'($urandom);
    if (poke) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 start = 1'b1; frame_len = K_W'($urandom_range(1, 100));
      @(posedge clk); #1 start = 1'b0;
    end
`ifdef LLR_SCHED_STALL_EN
    if (do_stall) begin
      repeat (2) @(posedge clk);
      #1 stall = 1'b1;
      hold = alpha_waddr;
      repeat (3) begin
        @(negedge clk);
        check("stall_alpha_en_low", alpha_en, 0);
        check("stall_waddr_hold", alpha_waddr, hold);
        @(posedge clk);
      end
      #1 stall = 1'b0;
      extra = 3;
    end
`else
    if (do_stall) $display("note: stall feature not built, ignoring stall request");
`endif
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("done_seen", done_cnt - d0, 1);
    repeat (4) @(posedge clk);
    check("done_once", done_cnt - d0, 1);
    check("busy_cycles", busy_cnt - b0, 2 * k + MAX_LAT + 1 + extra);
  endtask

  initial begin
    int d0, t;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    frame_len = '0;
    #12;
    check("reset_outputs_zero", all_outs(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs_zero", all_outs(), 0);

    run_frame(20, 1'b0, 1'b0);
    run_frame(8, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0);

    // Zero-length start must be ignored.
    @(posedge clk); #1 start = 1'b1; frame_len = '0;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("zero_len_busy", busy, 0);
    end

    run_frame(13, 1'b1, 1'b0);

    // Asynchronous reset mid-BWD aborts the frame.
    expect_frame(20);
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; frame_len = K_W'(20);
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (!beta_en && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reached_bwd", beta_en, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check("async_reset_outputs_zero", all_outs(), 0);
    flush();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    check("no_done_after_abort", done_cnt - d0, 0);
    run_frame(5, 1'b0, 1'b0);

`ifdef LLR_SCHED_STALL_EN
    run_frame(16, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 10; i++) begin
      run_frame($urandom_range(1, 45), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
